// File: rtl/lsu_arb_if.sv
// Bundle of the two master ports and the LSU bus around lsu_arbiter.
// slave  : the arbiter's view (masters' requests in, LSU bus out).
// master : the environment's view (masters plus the LSU itself).
interface lsu_arb_if;
    // Port 0 (CPU memory stage) and port 1 (debug/DMA) requests
    logic        req0;
    logic        req1;
    logic        lock0;
    logic        lock1;
    logic [11:0] addr0;
    logic [11:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        we0;
    logic        we1;
    logic [2:0]  rwsel0;
    logic [2:0]  rwsel1;

    // Handshake and response back to the masters
    logic        gnt0;
    logic        gnt1;
    logic        rvalid0;
    logic        rvalid1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;

    // Shared LSU bus
    logic [11:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_wren;
    logic [2:0]  lsu_rwsel;
    logic [31:0] lsu_rdata;

    // Handshake: a master raises req with lock/addr/wdata/we/rwsel and holds
    // them stable until the cycle gnt is high; gnt is combinational and the
    // access is taken on that clock edge. rvalid pulses for exactly one cycle,
    // the cycle after the grant, for loads and stores alike.
    modport slave (
        input  req0, req1, lock0, lock1, addr0, addr1, wdata0, wdata1,
               we0, we1, rwsel0, rwsel1, lsu_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               lsu_addr, lsu_wdata, lsu_wren, lsu_rwsel
    );

    modport master (
        output req0, req1, lock0, lock1, addr0, addr1, wdata0, wdata1,
               we0, we1, rwsel0, rwsel1, lsu_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               lsu_addr, lsu_wdata, lsu_wren, lsu_rwsel
    );
endinterface

// File: rtl/lsu_arbiter.sv
// Two-port round-robin arbiter in front of the single load/store unit.
// Port 0 is the CPU memory stage, port 1 the debug/DMA master. A port may
// hold the bus across an atomic sequence with lock, bounded by MAX_LOCK
// consecutive grants. Load data is registered and returned one cycle later.
module lsu_arbiter #(
    parameter int MAX_LOCK = 8
) (
    input  logic         clk,
    input  logic         rst,
    lsu_arb_if.slave     bus,
    output logic [1:0]   o_dbg_state,
    output logic         o_dbg_rr_ptr,
    output logic         o_dbg_resp_port
);

    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_rr_ptr;
    logic [CW-1:0] r_lock_cnt;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic [31:0]   r_rdata0;
    logic [31:0]   r_rdata1;
    logic          r_resp_port;

    logic          w_gnt0;
    logic          w_gnt1;
    logic [CW-1:0] w_cnt_inc;
    logic          w_hit_max;

    assign w_cnt_inc = r_lock_cnt + CW'(1);
    assign w_hit_max = (w_cnt_inc == LOCK_MAX);

    // Grant decision: round-robin in IDLE, owner-only while locked, none in reset
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    w_gnt0 = bus.req0 & (~bus.req1 | ~r_rr_ptr);
                    w_gnt1 = bus.req1 & (~bus.req0 |  r_rr_ptr);
                end
                ST_LOCK0: w_gnt0 = bus.req0;
                ST_LOCK1: w_gnt1 = bus.req1;
                default: begin
                    w_gnt0 = 1'b0;
                    w_gnt1 = 1'b0;
                end
            endcase
        end
    end

    // LSU bus mux: granted port's fields, otherwise a harmless idle load
    always_comb begin
        bus.lsu_addr  = 12'h000;
        bus.lsu_wdata = 32'h0000_0000;
        bus.lsu_wren  = 1'b0;
        bus.lsu_rwsel = 3'b010;
        if (w_gnt0) begin
            bus.lsu_addr  = bus.addr0;
            bus.lsu_wdata = bus.wdata0;
            bus.lsu_wren  = bus.we0;
            bus.lsu_rwsel = bus.rwsel0;
        end else if (w_gnt1) begin
            bus.lsu_addr  = bus.addr1;
            bus.lsu_wdata = bus.wdata1;
            bus.lsu_wren  = bus.we1;
            bus.lsu_rwsel = bus.rwsel1;
        end
    end

    // Arbitration FSM, lock counter and registered responses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= 1'b0;
            r_lock_cnt  <= '0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_rdata0    <= 32'h0000_0000;
            r_rdata1    <= 32'h0000_0000;
            r_resp_port <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt0;
            r_rvalid1 <= w_gnt1;
            if (w_gnt0 && !bus.we0) r_rdata0 <= bus.lsu_rdata;
            if (w_gnt1 && !bus.we1) r_rdata1 <= bus.lsu_rdata;
            if (w_gnt0 || w_gnt1)   r_resp_port <= w_gnt1;

            case (r_state)
                ST_IDLE: begin
                    // A lock with MAX_LOCK==1 is already exhausted by the first grant
                    if (w_gnt0) begin
                        r_rr_ptr <= 1'b1;
                        if (bus.lock0 && (MAX_LOCK > 1)) begin
                            r_state    <= ST_LOCK0;
                            r_lock_cnt <= CW'(1);
                        end
                    end else if (w_gnt1) begin
                        r_rr_ptr <= 1'b0;
                        if (bus.lock1 && (MAX_LOCK > 1)) begin
                            r_state    <= ST_LOCK1;
                            r_lock_cnt <= CW'(1);
                        end
                    end
                end
                ST_LOCK0: begin
                    if (!bus.lock0 || (w_gnt0 && w_hit_max)) begin
                        r_state    <= ST_IDLE;
                        r_lock_cnt <= '0;
                        r_rr_ptr   <= 1'b1;
                    end else if (w_gnt0) begin
                        r_lock_cnt <= w_cnt_inc;
                    end
                end
                ST_LOCK1: begin
                    if (!bus.lock1 || (w_gnt1 && w_hit_max)) begin
                        r_state    <= ST_IDLE;
                        r_lock_cnt <= '0;
                        r_rr_ptr   <= 1'b0;
                    end else if (w_gnt1) begin
                        r_lock_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_lock_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.gnt0    = w_gnt0;
    assign bus.gnt1    = w_gnt1;
    assign bus.rvalid0 = r_rvalid0;
    assign bus.rvalid1 = r_rvalid1;
    assign bus.rdata0  = r_rdata0;
    assign bus.rdata1  = r_rdata1;

    assign o_dbg_state     = r_state;
    assign o_dbg_rr_ptr    = r_rr_ptr;
    assign o_dbg_resp_port = r_resp_port;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter: reset, single load, round-robin, lock,
// forced lock release, reset mid-operation, idle bus and illegal rwsel.
module tb_lsu_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  logic       dbg_rr_ptr;
  logic       dbg_resp_port;
  int         n_checks;
  int         n_fail;

  lsu_arb_if u_if ();

  lsu_arbiter #(.MAX_LOCK(8)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (u_if),
    .o_dbg_state     (dbg_state),
    .o_dbg_rr_ptr    (dbg_rr_ptr),
    .o_dbg_resp_port (dbg_resp_port)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small LSU model: one known word at 0x004, address-derived data elsewhere
  always_comb begin
    if (u_if.lsu_addr == 12'h004) u_if.lsu_rdata = 32'hDEAD_BEEF;
    else                          u_if.lsu_rdata = {20'hABCDE, u_if.lsu_addr};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    u_if.req0 = 0; u_if.req1 = 0; u_if.lock0 = 0; u_if.lock1 = 0;
    u_if.addr0 = 0; u_if.addr1 = 0; u_if.wdata0 = 0; u_if.wdata1 = 0;
    u_if.we0 = 0; u_if.we1 = 0; u_if.rwsel0 = 3'b010; u_if.rwsel1 = 3'b010;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    n_checks++;
    if (dbg_rr_ptr !== 1'b0) begin n_fail++; $display("FAIL reset_rr_ptr got=%0b exp=0", dbg_rr_ptr); end
    n_checks++;
    if ({u_if.rvalid0, u_if.rvalid1} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=00", {u_if.rvalid0, u_if.rvalid1}); end
    n_checks++;
    if (u_if.rdata0 !== 32'h0 || u_if.rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h/%h exp=0/0", u_if.rdata0, u_if.rdata1); end
  endtask

  task automatic test_single_load();
    do_reset();
    u_if.req0 = 1; u_if.addr0 = 12'h004; u_if.we0 = 0; u_if.rwsel0 = 3'b010;
    #1;
    n_checks++;
    if ({u_if.gnt0, u_if.gnt1} !== 2'b10) begin n_fail++; $display("FAIL load_gnt got=%b exp=10", {u_if.gnt0, u_if.gnt1}); end
    n_checks++;
    if (u_if.lsu_wren !== 1'b0 || u_if.lsu_addr !== 12'h004) begin n_fail++; $display("FAIL load_bus got=wren%b addr%h exp=wren0 addr004", u_if.lsu_wren, u_if.lsu_addr); end
    tick();
    n_checks++;
    if (u_if.rvalid0 !== 1'b1) begin n_fail++; $display("FAIL load_rvalid got=%b exp=1", u_if.rvalid0); end
    n_checks++;
    if (u_if.rdata0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_rdata got=%h exp=deadbeef", u_if.rdata0); end
    idle_inputs();
    tick();
    n_checks++;
    if (u_if.rvalid0 !== 1'b0) begin n_fail++; $display("FAIL load_rvalid_pulse got=%b exp=0", u_if.rvalid0); end
  endtask

  task automatic test_round_robin();
    do_reset();
    u_if.req0 = 1; u_if.addr0 = 12'h010;
    u_if.req1 = 1; u_if.addr1 = 12'h020;
    for (int k = 0; k < 4; k++) begin
      logic exp0;
      exp0 = (k % 2 == 0);
      #1;
      n_checks++;
      if ({u_if.gnt0, u_if.gnt1} !== {exp0, ~exp0}) begin n_fail++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, {u_if.gnt0, u_if.gnt1}, {exp0, ~exp0}); end
      tick();
      n_checks++;
      if ({u_if.rvalid0, u_if.rvalid1} !== {exp0, ~exp0}) begin n_fail++; $display("FAIL rr_rvalid k=%0d got=%b exp=%b", k, {u_if.rvalid0, u_if.rvalid1}, {exp0, ~exp0}); end
    end
    n_checks++;
    if (u_if.rdata0 !== 32'hABCD_E010 || u_if.rdata1 !== 32'hABCD_E020) begin n_fail++; $display("FAIL rr_rdata got=%h/%h exp=abcde010/abcde020", u_if.rdata0, u_if.rdata1); end
    idle_inputs();
    tick();
  endtask

  task automatic test_lock_store();
    do_reset();
    // One port-0 access first so port 1 wins the next contended cycle
    u_if.req0 = 1; u_if.addr0 = 12'h010;
    #1;
    n_checks++;
    if (u_if.gnt0 !== 1'b1) begin n_fail++; $display("FAIL lock_pre_gnt0 got=%b exp=1", u_if.gnt0); end
    tick();
    u_if.req1 = 1; u_if.lock1 = 1; u_if.we1 = 1; u_if.wdata1 = 32'h12;
    u_if.addr1 = 12'h800; u_if.rwsel1 = 3'b000;
    for (int j = 0; j < 3; j++) begin
      #1;
      n_checks++;
      if ({u_if.gnt0, u_if.gnt1} !== 2'b01) begin n_fail++; $display("FAIL lock_gnt j=%0d got=%b exp=01", j, {u_if.gnt0, u_if.gnt1}); end
      n_checks++;
      if ({u_if.lsu_wren, u_if.lsu_addr, u_if.lsu_wdata, u_if.lsu_rwsel} !== {1'b1, 12'h800, 32'h12, 3'b000}) begin
        n_fail++; $display("FAIL lock_bus j=%0d got=%b %h %h %b exp=1 800 00000012 000", j, u_if.lsu_wren, u_if.lsu_addr, u_if.lsu_wdata, u_if.lsu_rwsel);
      end
      tick();
      n_checks++;
      if (u_if.rvalid1 !== 1'b1 || u_if.rdata1 !== 32'h0) begin n_fail++; $display("FAIL lock_resp j=%0d got=%b %h exp=1 00000000", j, u_if.rvalid1, u_if.rdata1); end
    end
    n_checks++;
    if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL lock_state got=%0d exp=2", dbg_state); end
    u_if.req1 = 0; u_if.lock1 = 0; u_if.we1 = 0;
    #1;
    n_checks++;
    if ({u_if.gnt0, u_if.gnt1, u_if.lsu_wren} !== 3'b000) begin n_fail++; $display("FAIL lock_release_cycle got=%b exp=000", {u_if.gnt0, u_if.gnt1, u_if.lsu_wren}); end
    tick();
    n_checks++;
    if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL lock_exit_state got=%0d exp=0", dbg_state); end
    #1;
    n_checks++;
    if (u_if.gnt0 !== 1'b1) begin n_fail++; $display("FAIL lock_after_gnt0 got=%b exp=1", u_if.gnt0); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_lock_max();
    do_reset();
    u_if.req0 = 1; u_if.lock0 = 1; u_if.addr0 = 12'h010;
    u_if.req1 = 1; u_if.addr1 = 12'h020;
    for (int g = 1; g <= 8; g++) begin
      #1;
      n_checks++;
      if ({u_if.gnt0, u_if.gnt1} !== 2'b10) begin n_fail++; $display("FAIL lockmax_gnt g=%0d got=%b exp=10", g, {u_if.gnt0, u_if.gnt1}); end
      tick();
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL lockmax_state got=%0d exp=0", dbg_state); end
    #1;
    n_checks++;
    if ({u_if.gnt0, u_if.gnt1} !== 2'b01) begin n_fail++; $display("FAIL lockmax_next_gnt got=%b exp=01", {u_if.gnt0, u_if.gnt1}); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    u_if.req0 = 1; u_if.lock0 = 1; u_if.addr0 = 12'h004;
    #1;
    n_checks++;
    if (u_if.gnt0 !== 1'b1) begin n_fail++; $display("FAIL rstmid_gnt got=%b exp=1", u_if.gnt0); end
    tick();
    rst = 1;
    u_if.we0 = 1; u_if.wdata0 = 32'h5555_AAAA;
    #1;
    n_checks++;
    if ({u_if.lsu_wren, u_if.gnt0, u_if.gnt1} !== 3'b000) begin n_fail++; $display("FAIL rstmid_wren got=%b exp=000", {u_if.lsu_wren, u_if.gnt0, u_if.gnt1}); end
    tick();
    rst = 0;
    idle_inputs();
    n_checks++;
    if (u_if.rvalid0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_rvalid got=%b exp=0", u_if.rvalid0); end
    n_checks++;
    if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rstmid_state got=%0d exp=0", dbg_state); end
    tick();
  endtask

  task automatic test_idle_and_rwsel();
    do_reset();
    u_if.req0 = 1; u_if.addr0 = 12'h004;
    tick();
    idle_inputs();
    // Illegal size code is passed through and still gets a response
    u_if.req1 = 1; u_if.addr1 = 12'h9A0; u_if.rwsel1 = 3'b111;
    #1;
    n_checks++;
    if (u_if.gnt1 !== 1'b1 || u_if.lsu_rwsel !== 3'b111) begin n_fail++; $display("FAIL rwsel_pass got=%b %b exp=1 111", u_if.gnt1, u_if.lsu_rwsel); end
    tick();
    idle_inputs();
    n_checks++;
    if (u_if.rvalid1 !== 1'b1 || u_if.rdata1 !== 32'hABCD_E9A0) begin n_fail++; $display("FAIL rwsel_resp got=%b %h exp=1 abcde9a0", u_if.rvalid1, u_if.rdata1); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({u_if.gnt0, u_if.gnt1, u_if.lsu_wren, u_if.rvalid0, u_if.rvalid1} !== 5'b00000) begin
        n_fail++; $display("FAIL idle_ctrl c=%0d got=%b exp=00000", c, {u_if.gnt0, u_if.gnt1, u_if.lsu_wren, u_if.rvalid0, u_if.rvalid1});
      end
      n_checks++;
      if (u_if.lsu_addr !== 12'h0 || u_if.lsu_wdata !== 32'h0 || u_if.lsu_rwsel !== 3'b010) begin
        n_fail++; $display("FAIL idle_bus c=%0d got=%h %h %b exp=000 00000000 010", c, u_if.lsu_addr, u_if.lsu_wdata, u_if.lsu_rwsel);
      end
      n_checks++;
      if (u_if.rdata0 !== 32'hDEAD_BEEF || u_if.rdata1 !== 32'hABCD_E9A0) begin
        n_fail++; $display("FAIL idle_rdata c=%0d got=%h/%h exp=deadbeef/abcde9a0", c, u_if.rdata0, u_if.rdata1);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1;
    idle_inputs();
    test_reset();
    test_single_load();
    test_round_robin();
    test_lock_store();
    test_lock_max();
    test_reset_mid_op();
    test_idle_and_rwsel();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
